// File: rtl/im_pkg.sv
// Shared instruction-memory constants and loader state encoding.
// Also imported by the instruction memory so depth/width stay in one place.
package im_pkg;
   localparam int IM_DEPTH_DEF = 64;
   localparam int IM_AW_DEF    = 6;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RECV  = 3'd1,
      WRITE = 3'd2,
      CHK   = 3'd3,
      DONE  = 3'd4
   } im_state_t;
endpackage

// File: rtl/im_loader_if.sv
// Byte-stream in / instruction-memory write port out for the loader.
// The master is the host side; the slave is im_loader.
interface im_loader_if
   import im_pkg::*;
#(
   parameter int IM_AW = IM_AW_DEF
);
   logic             start;
   logic [6:0]       nwords;
   logic             byte_valid;
   logic [7:0]       byte_data;
   logic             byte_ready;
   logic             we;
   logic [IM_AW-1:0] waddr;
   logic [31:0]      wdata;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      output start, nwords, byte_valid, byte_data,
      input  byte_ready, we, waddr, wdata, busy, done, err
   );

   modport slave (
      input  start, nwords, byte_valid, byte_data,
      output byte_ready, we, waddr, wdata, busy, done, err
   );
endinterface

// File: rtl/im_word_pack.sv
// Shifts accepted bytes into a 32-bit word, MSB byte first.
// word_full flags the beat carrying the fourth byte.
module im_word_pack
   import im_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        en,
   input  logic [7:0]  din,
   output logic [31:0] word,
   output logic        word_full
);
   logic [1:0] cnt;

   assign word_full = en && (cnt == 2'd3);

   // cnt wraps to 0 on the fourth byte, so no explicit clear between words
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         cnt  <= 2'd0;
         word <= 32'd0;
      end else if (en) begin
         cnt  <= cnt + 2'd1;
         word <= {word[23:0], din};
      end
   end
endmodule

// File: rtl/im_loader.sv
// Serial-byte instruction-memory loader: bytes -> 32-bit words -> IM writes.
// Define IM_LOADER_CHECKSUM_EN to add a trailing XOR checksum byte and err flag.
module im_loader
   import im_pkg::*;
#(
   parameter int IM_DEPTH = IM_DEPTH_DEF,
   parameter int IM_AW    = IM_AW_DEF
)(
   input  logic        clk,
   input  logic        rst_n,
   im_loader_if.slave  bus
);
   localparam logic [7:0] DEPTH8 = 8'(IM_DEPTH);

   im_state_t        state;
   logic [6:0]       nw;
   logic             byte_ready, we, busy, done;
   logic [IM_AW-1:0] waddr;
   logic [31:0]      word;
   logic             word_full, acc, start_ok, clr, last;

   assign acc      = bus.byte_valid && byte_ready;
   assign start_ok = bus.start && (bus.nwords != 7'd0) && ({1'b0, bus.nwords} <= DEPTH8);
   assign clr      = (state == IDLE) && start_ok;
   // waddr doubles as the words-written counter; last means this write ends the session
   assign last     = (8'(waddr) + 8'd1) >= {1'b0, nw};

   im_word_pack u_pack (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .en        (acc && (state == RECV)),
      .din       (bus.byte_data),
      .word      (word),
      .word_full (word_full)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         nw         <= 7'd0;
         waddr      <= '0;
         byte_ready <= 1'b0;
         we         <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_ok) begin
                  state      <= RECV;
                  nw         <= bus.nwords;
                  waddr      <= '0;
                  byte_ready <= 1'b1;
                  busy       <= 1'b1;
               end else if (bus.start) begin
                  state <= DONE;
                  busy  <= 1'b1;
                  done  <= 1'b1;
               end
            end
            RECV: begin
               if (word_full) begin
                  state      <= WRITE;
                  byte_ready <= 1'b0;
                  we         <= 1'b1;
               end
            end
            WRITE: begin
               we <= 1'b0;
               if (!last) begin
                  waddr      <= waddr + 1'b1;
                  state      <= RECV;
                  byte_ready <= 1'b1;
               end else begin
`ifdef IM_LOADER_CHECKSUM_EN
                  state      <= CHK;
                  byte_ready <= 1'b1;
`else
                  state <= DONE;
                  done  <= 1'b1;
`endif
               end
            end
            CHK: begin
               if (acc) begin
                  state      <= DONE;
                  byte_ready <= 1'b0;
                  done       <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef IM_LOADER_CHECKSUM_EN
   logic [7:0] xsum;
   logic       err;

   // err is sticky until the next accepted start
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         xsum <= 8'd0;
         err  <= 1'b0;
      end else if (acc && (state == RECV)) begin
         xsum <= xsum ^ bus.byte_data;
      end else if (acc && (state == CHK)) begin
         err <= (bus.byte_data != xsum);
      end
   end

   assign bus.err = err;
`else
   assign bus.err = 1'b0;
`endif

   assign bus.byte_ready = byte_ready;
   assign bus.we         = we;
   assign bus.waddr      = waddr;
   assign bus.wdata      = word;
   assign bus.busy       = busy;
   assign bus.done       = done;
endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader; follows IM_LOADER_CHECKSUM_EN when defined.
module tb_im_loader;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   im_loader_if #(.IM_AW(6)) bus();

   im_loader #(.IM_DEPTH(64), .IM_AW(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int vectors = 0;
   int miscompares = 0;
   int done_cnt = 0;
   logic [5:0]  log_addr[$];
   logic [31:0] log_data[$];
   logic [7:0]  bytes[256];

   // write/done monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (bus.we) begin
         log_addr.push_back(bus.waddr);
         log_data.push_back(bus.wdata);
      end
      if (bus.done) done_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic [6:0] n);
      bus.start  = 1'b1;
      bus.nwords = n;
      @(negedge clk);
      bus.start  = 1'b0;
   endtask

   task automatic put_byte(input logic [7:0] b, input int gap);
      int n = 0;
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
      while (!bus.byte_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("rdy_timeout", {31'd0, bus.byte_ready}, 32'd1);
      @(negedge clk);
      bus.byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic run_session(input int n, input int gap, input bit bad, input int ign_at);
      logic [7:0] x = 8'd0;
      int d0 = done_cnt;
      int w = 0;
      do_start(7'(n));
      for (int i = 0; i < 4 * n; i++) begin
         if (i == ign_at) begin
            bus.start  = 1'b1;
            bus.nwords = 7'd1;
            @(negedge clk);
            bus.start  = 1'b0;
         end
         put_byte(bytes[i], gap);
         x = x ^ bytes[i];
      end
`ifdef IM_LOADER_CHECKSUM_EN
      put_byte(x ^ {7'd0, bad}, gap);
`endif
      while (done_cnt == d0 && w < 2000) begin
         @(negedge clk);
         w++;
      end
      @(negedge clk);
      @(negedge clk);
      chk("done_pulses", done_cnt - d0, 1);
      chk("busy_after", {31'd0, bus.busy}, 0);
   endtask

   initial begin
      int base;
      logic [7:0] s1[8] = '{8'h20, 8'h08, 8'h00, 8'h20, 8'h20, 8'h09, 8'h00, 8'h37};
      bus.start = 1'b0; bus.nwords = 7'd0;
      bus.byte_valid = 1'b0; bus.byte_data = 8'd0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'd0, bus.byte_ready}, 0);
      chk("rst_we",    {31'd0, bus.we}, 0);
      chk("rst_waddr", {26'd0, bus.waddr}, 0);
      chk("rst_wdata", bus.wdata, 0);
      chk("rst_busy",  {31'd0, bus.busy}, 0);
      chk("rst_done",  {31'd0, bus.done}, 0);
      chk("rst_err",   {31'd0, bus.err}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // two words back-to-back, then with 3-cycle gaps
      for (int g = 0; g < 2; g++) begin
         for (int i = 0; i < 8; i++) bytes[i] = s1[i];
         base = log_addr.size();
         run_session(2, g * 3, 1'b0, -1);
         chk("two_nwr", log_addr.size() - base, 2);
         chk("two_a0", {26'd0, log_addr[base]}, 0);
         chk("two_d0", log_data[base], 32'h20080020);
         chk("two_a1", {26'd0, log_addr[base+1]}, 1);
         chk("two_d1", log_data[base+1], 32'h20090037);
`ifndef IM_LOADER_CHECKSUM_EN
         chk("two_err", {31'd0, bus.err}, 0);
`endif
      end

      // out-of-range word counts go straight to DONE
      for (int k = 0; k < 2; k++) begin
         base = log_addr.size();
         do_start(k == 0 ? 7'd0 : 7'd65);
         chk("bad_done", {31'd0, bus.done}, 1);
         @(negedge clk);
         chk("bad_done_off", {31'd0, bus.done}, 0);
         chk("bad_busy", {31'd0, bus.busy}, 0);
         chk("bad_nwr", log_addr.size() - base, 0);
      end

      // full 64-word session with a start pulse injected mid-stream
      for (int i = 0; i < 256; i++) bytes[i] = 8'(i * 7 + 3);
      base = log_addr.size();
      run_session(64, 0, 1'b0, 10);
      repeat (10) @(negedge clk);
      chk("full_nwr", log_addr.size() - base, 64);
      for (int i = 0; i < 64; i++) begin
         chk("full_addr", {26'd0, log_addr[base+i]}, i);
         chk("full_data", log_data[base+i],
             {bytes[4*i], bytes[4*i+1], bytes[4*i+2], bytes[4*i+3]});
      end

      // reset mid-word aborts the session
      base = log_addr.size();
      do_start(7'd1);
      put_byte(8'h11, 0);
      put_byte(8'h22, 0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_ready", {31'd0, bus.byte_ready}, 0);
      chk("abort_we",    {31'd0, bus.we}, 0);
      chk("abort_waddr", {26'd0, bus.waddr}, 0);
      chk("abort_wdata", bus.wdata, 0);
      chk("abort_busy",  {31'd0, bus.busy}, 0);
      chk("abort_done",  {31'd0, bus.done}, 0);
      chk("abort_err",   {31'd0, bus.err}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_nwr", log_addr.size() - base, 0);
      bytes[0] = 8'hDE; bytes[1] = 8'hAD; bytes[2] = 8'hBE; bytes[3] = 8'hEF;
      run_session(1, 0, 1'b0, -1);
      chk("post_nwr", log_addr.size() - base, 1);
      chk("post_a0", {26'd0, log_addr[base]}, 0);
      chk("post_d0", log_data[base], 32'hDEADBEEF);

`ifdef IM_LOADER_CHECKSUM_EN
      bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03; bytes[3] = 8'h04;
      run_session(1, 0, 1'b0, -1);
      chk("cks_good_err", {31'd0, bus.err}, 0);
      run_session(1, 0, 1'b1, -1);
      chk("cks_bad_err", {31'd0, bus.err}, 1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 SHALL have parameter IM_DEPTH, default 64, meaning number of 32-bit instruction-memory words.
REQ-002 SHALL have parameter IM_AW, default 6, meaning write-address width (log2 IM_DEPTH).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port start  input  1  begin a load session (sampled in IDLE only).
REQ-006 SHALL have port nwords  input  7  word count for the session, latched on accepted start.
REQ-007 SHALL have port byte_valid  input  1  source presents byte_data.
REQ-008 SHALL have port byte_data  input  8  serial instruction byte, MSB byte of each word first.
REQ-009 SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 SHALL have port we  output  1  instruction-memory write strobe.
REQ-011 SHALL have port waddr  output  IM_AW  instruction-memory word address.
REQ-012 SHALL have port wdata  output  32  instruction word to write.
REQ-013 SHALL have port busy  output  1  session in progress; CPU held while high.
REQ-014 SHALL have port done  output  1  one-cycle pulse at session end.
REQ-015 SHALL have port err  output  1  checksum failure flag (see Configuration).

Function
REQ-016 SHALL implement states IDLE, RECV, WRITE, CHK, DONE.
REQ-017 SHALL move IDLE->RECV on start=1 with nwords in 1..IM_DEPTH, clearing word counter, waddr and err.
REQ-018 SHALL treat start with nwords=0 or nwords>IM_DEPTH as IDLE->DONE with no writes.
REQ-019 SHALL ignore start in any state other than IDLE.
REQ-020 SHALL drive byte_ready=1 only in RECV (and in CHK when enabled); a byte transfers when byte_valid&&byte_ready on the clock edge.
REQ-021 SHALL shift accepted bytes into a 32-bit word, first byte ending in bits [31:24], fourth in [7:0].
REQ-022 SHALL enter WRITE on the edge accepting the fourth byte; in WRITE drive we=1 for exactly one cycle with waddr=current word index and wdata=assembled word.
REQ-023 SHALL, leaving WRITE, increment waddr and go to RECV if words written < nwords, otherwise to CHK (macro defined) or DONE.
REQ-024 SHALL hold state and partial word unchanged on cycles with byte_valid=0 (arbitrary gaps).
REQ-025 SHALL never wrap waddr: the last write of a 64-word session is at address 63, after which no further write occurs.
REQ-026 SHALL assert done=1 for one cycle in DONE, then return to IDLE; busy=1 in RECV, WRITE, CHK, DONE.
REQ-027 SHALL hold we=0 in all states except WRITE; wdata/waddr are don't-care when we=0 but SHALL be stable for the WRITE cycle.

Reset
REQ-028 SHALL, on rising clk with rst_n=0, enter IDLE with byte_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, err=0, counters and partial word cleared.
REQ-029 SHALL abort any session on reset mid-operation; partially assembled bytes are discarded and no write is issued on the reset cycle.

Configuration
REQ-030 SHALL, with IM_LOADER_CHECKSUM_EN defined, accept one extra byte in CHK after the last write, compare it with the XOR of all data bytes of the session, set err=1 on mismatch (held until next accepted start), then enter DONE.
REQ-031 SHALL, without IM_LOADER_CHECKSUM_EN, omit CHK and the XOR register, go WRITE->DONE directly, and tie err=0.

Structure
REQ-032 SHALL take IM_DEPTH, IM_AW defaults and the state encoding from shared package im_pkg, also used by the instruction memory.
REQ-033 SHALL place byte-to-word shifting and byte counting in sub-module im_word_pack (outputs word and word_full strobe).

Verification
REQ-034 SHALL cover: nwords=2, bytes 20 08 00 20 20 09 00 37 back-to-back -> we at waddr 0 wdata 32'h20080020, we at waddr 1 wdata 32'h20090037, done pulse, busy low after.
REQ-035 SHALL cover: same stream with byte_valid low 3 cycles between every byte -> identical writes, no extra we.
REQ-036 SHALL cover: start with nwords=0 and nwords=65 -> no we, done pulses one cycle later, busy back low.
REQ-037 SHALL cover: nwords=64, 256 bytes -> 64 writes, last at waddr 63, no 65th write, start while busy ignored.
REQ-038 SHALL cover: rst_n=0 after 2 bytes of word 1 -> IDLE, all outputs zero; new session then writes waddr 0 correctly.
REQ-039 SHALL cover (macro defined): nwords=1, bytes 01 02 03 04 checksum 04 -> err=0; checksum 05 -> err=1 after done.
